// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling UART receive stage feeding the receive FIFO.
// Validates the start bit, frames one character (LSB first, optional parity,
// one stop bit), presents good characters on Rx_Data with a one-clock
// Data_Rdy strobe and reports per-frame parity/framing status.
//
// Ports:
//   clk        system clock (only clock in the block)
//   rst        synchronous, active-high reset
//   Rx_Serial  asynchronous serial line, idles high
//   Rx_Data    last good character received
//   Data_Rdy   one-clock pulse, one clock after Rx_Data updates
//   Parity_Err parity result of the last completed frame
//   Frame_Err  stop-bit result of the last completed frame
//   Rx_Busy    high whenever the receiver is not idle
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 27,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Rx_Busy
);

    localparam int unsigned DivW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(BAUD_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone,
        StWaitIdle
    } state_e;

    state_e               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [DivW-1:0]      r_div;
    logic [3:0]           r_smp;
    logic [BitW-1:0]      r_bits;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_rx_s;
    logic w_tick;
    logic w_mid_start;
    logic w_mid_bit;
    logic w_par_err;

    assign w_rx_s      = r_sync2;
    assign w_tick      = (r_div == DivLast);
    // 8th tick after the falling edge lands mid start bit; every 16th after that is mid-bit
    assign w_mid_start = w_tick && (r_smp == 4'd7);
    assign w_mid_bit   = w_tick && (r_smp == 4'd15);
    assign w_par_err   = w_rx_s ^ (^r_shift) ^ PARITY_ODD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_div     <= '0;
            r_smp     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= Rx_Serial;
            r_sync2 <= r_sync1;
            r_rdy   <= 1'b0;

            // Divider and sample counter run in every non-idle state
            if (r_state != StIdle) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_smp <= r_smp + 4'd1;
                end
            end

            unique case (r_state)
                StIdle: begin
                    r_div <= '0;
                    r_smp <= '0;
                    if (!w_rx_s) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (w_mid_start) begin
                        if (w_rx_s) begin
                            r_state <= StIdle;  // glitch, not a start bit
                        end else begin
                            r_smp   <= '0;
                            r_bits  <= '0;
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_mid_bit) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits == BitLast) begin
                            r_state <= PARITY_EN ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (w_mid_bit) begin
                        r_par_err <= w_par_err;
                        r_state   <= StStop;
                    end
                end
                StStop: begin
                    if (w_mid_bit) begin
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_perr  <= PARITY_EN ? r_par_err : 1'b0;
                            r_ferr  <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            // Data and strobe untouched on a bad stop bit
                            r_ferr  <= 1'b1;
                            r_perr  <= 1'b0;
                            r_state <= StWaitIdle;
                        end
                    end
                end
                StDone: begin
                    r_rdy   <= 1'b1;
                    r_state <= StIdle;
                end
                StWaitIdle: begin
                    // A held-low line (break) yields only one framing error
                    if (w_rx_s) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Rx_Data    = r_data;
    assign Data_Rdy   = r_rdy;
    assign Parity_Err = r_perr;
    assign Frame_Err  = r_ferr;
    assign Rx_Busy    = (r_state != StIdle);

endmodule
